// File: rtl/sync_decoder.sv
// Recovers pixel coordinates, an active-video window and a lock indication from
// asynchronous hsync/vsync by measuring line and frame lengths against expected timing.
module sync_decoder #(
    parameter int H_PX = 800,
    parameter int V_LN = 524,
    parameter int BP_H = 144,
    parameter int BP_V = 33
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       von,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_len,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0]  L_H_PX = 10'(H_PX);
    localparam logic [9:0]  L_V_LN = 10'(V_LN);
    localparam logic [11:0] L_BP_H = 12'(BP_H);
    localparam logic [11:0] L_BP_V = 12'(BP_V);
    localparam logic [9:0]  L_MAX  = 10'd1023;

    logic [2:0]  r_hs_sync;
    logic [2:0]  r_vs_sync;
    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic [9:0]  r_hcnt;
    logic        r_bad_line;
    state_t      r_state;

    logic        w_hfall;
    logic        w_vfall;
    logic [9:0]  w_hc_next;
    logic [9:0]  w_line_new;
    logic [9:0]  w_frame_new;
    logic        w_line_bad;
    logic        w_frame_bad;
    logic        w_bad_now;
    logic        w_hc_sat;
    logic [11:0] w_h_diff;
    logic [11:0] w_v_diff;
    logic        w_active;

    // Index 0/1 form the synchronizer, index 2 holds the previous synchronized level.
    assign w_hfall     = ~r_hs_sync[1] & r_hs_sync[2];
    assign w_vfall     = ~r_vs_sync[1] & r_vs_sync[2];
    assign w_line_new  = r_hc + 10'd1;
    assign w_line_bad  = w_hfall & (w_line_new != L_H_PX);
    assign w_frame_bad = (w_frame_new != L_V_LN);
    assign w_bad_now   = r_bad_line | w_line_bad;
    assign w_hc_sat    = (w_hc_next == L_MAX);

    // A borrow out of the 12-bit difference means the counter is still before the window.
    assign w_h_diff = {2'b00, r_hc} - L_BP_H;
    assign w_v_diff = {2'b00, r_vc} - L_BP_V;
    assign w_active = ~w_h_diff[11] & (w_h_diff[10:0] <= 11'd639) &
                      ~w_v_diff[11] & (w_v_diff[10:0] <= 11'd479);

    // Next horizontal count and the frame length that a vsync fall would capture now.
    always_comb begin
        w_hc_next   = r_hc;
        w_frame_new = r_hcnt;
        if (w_hfall) begin
            w_hc_next = 10'd0;
        end else if (r_hc != L_MAX) begin
            w_hc_next = r_hc + 10'd1;
        end else begin
            w_hc_next = L_MAX;
        end
        if (r_hcnt == L_MAX) begin
            w_frame_new = L_MAX;
        end else begin
            w_frame_new = r_hcnt + {9'd0, w_hfall};
        end
    end

    // Synchronizers; idle (high) during reset so release cannot fake a fall.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_hs_sync <= 3'b111;
            r_vs_sync <= 3'b111;
        end else begin
            r_hs_sync <= {r_hs_sync[1:0], hsync_in};
            r_vs_sync <= {r_vs_sync[1:0], vsync_in};
        end
    end

    // Pixel/line counters and line/frame length capture.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_hc      <= 10'd0;
            r_vc      <= 10'd0;
            r_hcnt    <= 10'd0;
            line_len  <= 10'd0;
            frame_len <= 10'd0;
        end else begin
            r_hc <= w_hc_next;
            if (w_hfall) begin
                line_len <= w_line_new;
            end
            if (w_vfall) begin
                r_vc      <= 10'd0;
                r_hcnt    <= 10'd0;
                frame_len <= w_frame_new;
            end else if (w_hfall) begin
                r_vc   <= (r_vc == L_MAX) ? L_MAX : r_vc + 10'd1;
                r_hcnt <= (r_hcnt == L_MAX) ? L_MAX : r_hcnt + 10'd1;
            end
        end
    end

    // Registered window outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            h   <= 10'd0;
            v   <= 10'd0;
            von <= 1'b0;
        end else begin
            von <= locked & w_active;
            if (w_active) begin
                h <= w_h_diff[9:0];
                v <= w_v_diff[9:0];
            end else begin
                h <= 10'd0;
                v <= 10'd0;
            end
        end
    end

    // Lock FSM; decisions use the lengths being captured this cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= SEARCH;
            r_bad_line <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            case (r_state)
                SEARCH: begin
                    if (w_vfall) begin
                        r_state    <= MEASURE;
                        r_bad_line <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_vfall) begin
                        r_bad_line <= 1'b0;
                        if (!w_frame_bad && !w_bad_now) begin
                            r_state <= LOCKED;
                            locked  <= 1'b1;
                        end
                    end else if (w_line_bad) begin
                        r_bad_line <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_line_bad || (w_vfall && w_frame_bad) || w_hc_sat) begin
                        r_state  <= SEARCH;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_decoder.sv
// Directed bench for sync_decoder: instance A (800-cycle lines, 6-line frames) covers
// lock, horizontal window, error and reset; instance B (16-cycle lines) covers rows 33/512.
module tb_sync_decoder;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       hs_a, vs_a, hs_b, vs_b;
    logic [9:0] h_a, v_a, ll_a, fl_a, h_b, v_b, ll_b, fl_b;
    logic       von_a, lk_a, err_a, von_b, lk_b, err_b;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hw     = 96;
    bit sel    = 1'b0;

    always #5 clk = ~clk;

    sync_decoder #(.H_PX(800), .V_LN(6), .BP_H(144), .BP_V(2)) u_dut_a (
        .clk(clk), .clr_n(clr_n), .hsync_in(hs_a), .vsync_in(vs_a),
        .h(h_a), .v(v_a), .von(von_a), .locked(lk_a),
        .line_len(ll_a), .frame_len(fl_a), .sync_err(err_a)
    );

    sync_decoder #(.H_PX(16), .V_LN(524), .BP_H(0), .BP_V(33)) u_dut_b (
        .clk(clk), .clr_n(clr_n), .hsync_in(hs_b), .vsync_in(vs_b),
        .h(h_b), .v(v_b), .von(von_b), .locked(lk_b),
        .line_len(ll_b), .frame_len(fl_b), .sync_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_hv"}, 32'({h_a, v_a}), 32'd0);
        chk({tag, "_len"}, 32'({ll_a, fl_a}), 32'd0);
        chk({tag, "_flags"}, 32'({von_a, lk_a, err_a}), 32'd0);
    endtask

    // Advance to the next falling clock edge; release hsync after its pulse width.
    task automatic tick();
        @(negedge clk);
        hs_cnt++;
        if (hs_cnt == hw) begin
            if (sel) hs_b = 1'b1;
            else     hs_a = 1'b1;
        end
    endtask

    task automatic hfall(input bit vlow, input bit vhigh);
        hs_cnt = 0;
        if (sel) begin
            hs_b = 1'b0;
            if (vlow)  vs_b = 1'b0;
            if (vhigh) vs_b = 1'b1;
        end else begin
            hs_a = 1'b0;
            if (vlow)  vs_a = 1'b0;
            if (vhigh) vs_a = 1'b1;
        end
    endtask

    task automatic line(input int len, input bit vlow, input bit vhigh);
        hfall(vlow, vhigh);
        repeat (len) tick();
    endtask

    task automatic lines(input int n, input int len, input int first);
        for (int i = 0; i < n; i++) line(len, 1'b0, (first + i) == 2);
    endtask

    function automatic logic [31:0] exp_win(input int hc, input int vc, input int bph, input int bpv);
        if (hc >= bph && hc <= bph + 639 && vc >= bpv && vc <= bpv + 479)
            return {11'd0, 1'b1, 10'(hc - bph), 10'(vc - bpv)};
        return 32'd0;
    endfunction

    function automatic logic [31:0] obs_win();
        return sel ? {11'd0, von_b, h_b, v_b} : {11'd0, von_a, h_a, v_a};
    endfunction

    // Outputs at sample t reflect the counters of t-4 cycles after the line's pin fall.
    task automatic chk_line(input int len, input int vc, input int bph, input int bpv, input bit vhigh);
        hfall(1'b0, vhigh);
        for (int t = 1; t <= len; t++) begin
            tick();
            chk("window", obs_win(),
                exp_win((t >= 4) ? t - 4 : len + t - 4, (t >= 4) ? vc : vc - 1, bph, bpv));
        end
    endtask

    initial begin
        clr_n = 1'b0;
        hs_a = 1'b1; vs_a = 1'b1; hs_b = 1'b1; vs_b = 1'b1;
        repeat (3) tick();
        chk_idle("reset");
        clr_n = 1'b1;
        repeat (2) tick();

        // Frame 1: first vsync fall only enters MEASURE
        hfall(1'b1, 1'b0); repeat (3) tick();
        chk("f1_locked", 32'(lk_a), 32'd0);
        repeat (797) tick();
        lines(5, 800, 1);

        // Frame 2: second vsync fall locks
        hfall(1'b1, 1'b0); repeat (2) tick();
        chk("f2_locked_pre", 32'(lk_a), 32'd0);
        tick();
        chk("f2_locked", 32'(lk_a), 32'd1);
        chk("f2_frame_len", 32'(fl_a), 32'd6);
        chk("f2_line_len", 32'(ll_a), 32'd800);
        repeat (797) tick();
        chk_line(800, 1, 144, 2, 1'b0);
        chk_line(800, 2, 144, 2, 1'b1);
        lines(3, 800, 3);

        // Frame 3: line 2 stretched to 801 cycles
        line(800, 1'b1, 1'b0);
        line(800, 1'b0, 1'b0);
        line(801, 1'b0, 1'b1);
        hfall(1'b0, 1'b0); repeat (3) tick();
        chk("stretch_err", 32'(err_a), 32'd1);
        chk("stretch_locked", 32'(lk_a), 32'd0);
        chk("stretch_line_len", 32'(ll_a), 32'd801);
        tick();
        chk("stretch_err_end", 32'(err_a), 32'd0);
        repeat (796) tick();
        lines(2, 800, 4);

        // Frames 4 and 5: relock on the second good vsync fall
        hfall(1'b1, 1'b0); repeat (3) tick();
        chk("f4_locked", 32'(lk_a), 32'd0);
        repeat (797) tick();
        lines(5, 800, 1);
        hfall(1'b1, 1'b0); repeat (3) tick();
        chk("f5_relock", 32'(lk_a), 32'd1);
        chk("f5_err", 32'(err_a), 32'd0);
        repeat (797) tick();
        lines(2, 800, 1);

        // hsync stops: hc reaches 1023 at sample 1026
        hfall(1'b0, 1'b0); repeat (1025) tick();
        chk("sat_err_pre", 32'(err_a), 32'd0);
        chk("sat_locked_pre", 32'(lk_a), 32'd1);
        tick();
        chk("sat_err", 32'(err_a), 32'd1);
        chk("sat_locked", 32'(lk_a), 32'd0);
        tick();
        chk("sat_err_end", 32'(err_a), 32'd0);
        chk("sat_von", 32'(von_a), 32'd0);

        // Frame 6 of 5 lines measured, then a good frame locks
        hfall(1'b1, 1'b0); repeat (3) tick();
        chk("f6_locked", 32'(lk_a), 32'd0);
        repeat (797) tick();
        lines(4, 800, 1);
        hfall(1'b1, 1'b0); repeat (3) tick();
        chk("f7_frame_len", 32'(fl_a), 32'd5);
        chk("f7_locked", 32'(lk_a), 32'd0);
        repeat (797) tick();
        lines(5, 800, 1);
        hfall(1'b1, 1'b0); repeat (3) tick();
        chk("f8_frame_len", 32'(fl_a), 32'd6);
        chk("f8_locked", 32'(lk_a), 32'd1);
        repeat (797) tick();
        lines(2, 800, 1);

        // Reset mid-line while locked
        hfall(1'b0, 1'b0); repeat (400) tick();
        chk("pre_rst_win", obs_win(), exp_win(396, 3, 144, 2));
        clr_n = 1'b0;
        #1;
        chk_idle("async_rst");
        repeat (2) tick();
        chk_idle("held_rst");
        clr_n = 1'b1;
        repeat (20) tick();
        chk("post_rst_len", 32'({ll_a, fl_a}), 32'd0);
        chk("post_rst_flags", 32'({von_a, lk_a, err_a}), 32'd0);
        hfall(1'b1, 1'b0); repeat (3) tick();
        chk("post_rst_nolock", 32'(lk_a), 32'd0);
        repeat (797) tick();

        // Instance B: vertical window boundaries
        sel = 1'b1;
        hw  = 4;
        clr_n = 1'b0;
        repeat (2) tick();
        clr_n = 1'b1;
        tick();
        line(16, 1'b1, 1'b0);
        lines(523, 16, 1);
        hfall(1'b1, 1'b0); repeat (3) tick();
        chk("b_locked", 32'(lk_b), 32'd1);
        chk("b_frame_len", 32'(fl_b), 32'd524);
        chk("b_line_len", 32'(ll_b), 32'd16);
        repeat (13) tick();
        lines(31, 16, 1);
        chk_line(16, 32, 0, 33, 1'b0);
        chk_line(16, 33, 0, 33, 1'b0);
        lines(478, 16, 34);
        chk_line(16, 512, 0, 33, 1'b0);
        chk_line(16, 513, 0, 33, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_decoder.md
SYNC_DECODER -- requirements
Module: sync_decoder

Interface
REQ-001 Parameter H_PX, default 800: expected clk cycles per line.
REQ-002 Parameter V_LN, default 524: expected lines per frame.
REQ-003 Parameter BP_H, default 144: hc value of the first active pixel.
REQ-004 Parameter BP_V, default 33: vc value of the first active line.
REQ-005 Port clk, input, 1 bit: single clock (pixel clock); all logic on its rising edge.
REQ-006 Port clr_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port hsync_in, input, 1 bit: horizontal sync, active-low pulse, asynchronous to clk.
REQ-008 Port vsync_in, input, 1 bit: vertical sync, active-low pulse, asynchronous to clk.
REQ-009 Port h, output, 10 bits: recovered pixel column, 0..639.
REQ-010 Port v, output, 10 bits: recovered pixel row, 0..479.
REQ-011 Port von, output, 1 bit: recovered active-video window, valid only while locked.
REQ-012 Port locked, output, 1 bit: timing lock indicator.
REQ-013 Port line_len, output, 10 bits: last measured line length in clk cycles.
REQ-014 Port frame_len, output, 10 bits: last measured frame length in lines.
REQ-015 Port sync_err, output, 1 bit: one-cycle pulse when lock is lost.

Function
REQ-016 Each sync input SHALL pass through a 2-flop synchronizer, followed by a third register used for falling-edge detection.
REQ-017 A fall event SHALL assert for exactly one cycle, when the synchronized value is 0 and the previous synchronized value was 1.
REQ-018 With the pin low from before edge k: the fall event SHALL assert in the cycle after edge k+1, and hc SHALL read 0 after edge k+2.
REQ-019 hc (10 bits) SHALL load 0 on an hsync fall; otherwise it SHALL increment, saturating at 1023.
REQ-020 On an hsync fall, line_len SHALL load hc+1, and vc SHALL increment, saturating at 1023.
REQ-021 On a vsync fall, frame_len SHALL load the count of hsync falls since the previous vsync fall, and vc SHALL load 0.
REQ-022 For REQ-021, an hsync fall in the same cycle as the vsync fall SHALL count toward the ending frame, and vc SHALL still load 0.
REQ-023 Active window: BP_H <= hc <= BP_H+639 and BP_V <= vc <= BP_V+479.
REQ-024 h and v SHALL be registered, equal to hc-BP_H and vc-BP_V inside the active window, and 0 outside it.
REQ-025 von SHALL be registered and SHALL equal locked AND (active window).
REQ-026 The lock FSM SHALL have three states: SEARCH, MEASURE, LOCKED.
REQ-027 SEARCH SHALL go to MEASURE on a vsync fall; line lengths are ignored in SEARCH.
REQ-028 MEASURE SHALL track a bad_line flag, set by any hsync fall with hc+1 != H_PX and cleared on each vsync fall.
REQ-029 On a vsync fall in MEASURE, the FSM SHALL go to LOCKED if the new frame_len == V_LN and bad_line == 0; otherwise it SHALL remain in MEASURE for a new frame.
REQ-030 In LOCKED, any of these SHALL cause a transition to SEARCH with sync_err pulsed high for one cycle: hsync fall with hc+1 != H_PX; vsync fall with frame count != V_LN; hc reaching 1023.
REQ-031 locked SHALL be 1 only in state LOCKED.
REQ-032 The value checks in REQ-029 and REQ-030 SHALL use the values being captured in that same cycle, not the previously held registers.

Reset
REQ-033 While clr_n = 0, all synchronizer flops SHALL be 1 (idle sync level), so no false fall is produced on reset release.
REQ-034 While clr_n = 0: hc, vc, h, v, line_len, frame_len = 0; von, locked, sync_err = 0; FSM = SEARCH.
REQ-035 Reset asserted mid-frame SHALL take effect immediately, with no sync_err pulse.
REQ-036 After reset release, lock SHALL require a full SEARCH -> MEASURE -> LOCKED sequence.

Verification
REQ-037 Drive nominal 800x524 timing (hsync low for 96 cycles, vsync low for 2 lines) from reset. Required: locked rises on the 2nd vsync fall; frame_len = 524; line_len = 800.
REQ-038 While locked, check the window. Required: von = 1 exactly for hc 144..783 and vc 33..512; h = 0 at hc = 144, h = 639 at hc = 783; v = 479 at vc = 512.
REQ-039 While locked, stretch one line to 801 cycles. Required: one sync_err pulse; locked = 0; line_len = 801; relock after 2 further good vsync falls.
REQ-040 Stop hsync while locked. Required: hc saturates at 1023, sync_err pulses at that cycle, FSM enters SEARCH, von = 0.
REQ-041 Drive a frame of 520 lines during MEASURE. Required: frame_len = 520, no lock; the following 524-line frame locks.
REQ-042 Pulse clr_n low mid-line while locked. Required: all outputs 0 immediately, no sync_err pulse, no spurious fall event after release.
